arb_grant_sched: RTL and testbench

Round-robin grant scheduler sitting directly upstream of the source arbiter. Collects per-source requests and produces the registered one-hot `n_mult_en` select vector that the arbiter uses to route one `arb_struct_t` source to its output. Holds each grant until the downstream consumer accepts the transfer, then rotates priority so no source starves. By construction it never drives more than one select bit, which satisfies the arbiter's one-hot requirement.

---
 rtl/arb_grant_sched.sv | 166 ++++++++++++++++
 tb/tb_arb_grant_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_grant_sched.sv
// Round-robin grant scheduler feeding the source arbiter's one-hot select.
// Holds a grant until the consumer accepts it, then rotates priority past it.
// Optional compile macro ARB_SCHED_BURST_EN: keep a grant for up to MAX_BURST
// beats or until `last`. Undefined: every accepted beat ends the grant.
module arb_grant_sched #(
    parameter int unsigned SOURCES   = 4,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IDX_W    = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [SOURCES-1:0] req,
    input  logic               xfer_ready,
    input  logic               last,
    output logic [SOURCES-1:0] n_mult_en,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SOURCES-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic               end_beat_c;
    logic               rel_c;
    logic               load_c;
    logic [IDX_W-1:0]   ptr_rel_c;
    logic [IDX_W:0]     pick_idle_c;
    logic [IDX_W:0]     pick_rel_c;

    // First set request at or after p, wrapping; returns {found, index}.
    function automatic logic [IDX_W:0] pick_winner(input logic [SOURCES-1:0] r,
                                                   input logic [IDX_W-1:0]   p);
        logic               found;
        logic [IDX_W-1:0]   win;
        logic [SOURCES-1:0] sh;
        int unsigned        k;
        found = 1'b0;
        win   = '0;
        for (int unsigned off = 0; off < SOURCES; off++) begin
            k  = (32'(p) + off) % SOURCES;
            sh = r >> k;
            if (!found && sh[0]) begin
                found = 1'b1;
                win   = IDX_W'(k);
            end
        end
        return {found, win};
    endfunction

    // Binary index to one-hot select.
    function automatic logic [SOURCES-1:0] to_onehot(input logic [IDX_W-1:0] i);
        return SOURCES'(1) << i;
    endfunction

`ifdef ARB_SCHED_BURST_EN
    localparam logic [8:0] MAX_BURST_W = 9'(MAX_BURST);
    localparam logic [7:0] BEAT_SAT    = 8'(MAX_BURST);

    logic [7:0] beat_q, beat_d;

    // Grant ends on an accepted final beat or when the burst budget is used up.
    assign end_beat_c = xfer_ready && (last || (({1'b0, beat_q} + 9'd1) == MAX_BURST_W));

    // Beat counter: cleared on each new grant, saturating count of held beats.
    always_comb begin
        beat_d = beat_q;
        if (load_c) begin
            beat_d = '0;
        end else if ((state_q == S_GRANT) && !rel_c && xfer_ready && (beat_q < BEAT_SAT)) begin
            beat_d = beat_q + 8'd1;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end
`else
    logic unused_ok;

    // Single-beat round-robin: every accepted beat ends the grant.
    assign end_beat_c = xfer_ready;
    assign unused_ok  = ^{last, load_c, 8'(MAX_BURST)};
`endif

    // Release when the beat finishes the grant or the owner drops its request.
    assign rel_c      = (state_q == S_GRANT) && (end_beat_c || ((req & grant_q) == '0));
    assign ptr_rel_c  = (idx_q == IDX_W'(SOURCES - 1)) ? '0 : idx_q + IDX_W'(1);
    assign pick_idle_c = pick_winner(req, ptr_q);
    assign pick_rel_c  = pick_winner(req & ~grant_q, ptr_rel_c);

    // Next-state and grant selection.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        load_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_idle_c[IDX_W]) begin
                    idx_d   = pick_idle_c[IDX_W-1:0];
                    grant_d = to_onehot(pick_idle_c[IDX_W-1:0]);
                    valid_d = 1'b1;
                    load_c  = 1'b1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (rel_c) begin
                    ptr_d = ptr_rel_c;
                    if (pick_rel_c[IDX_W]) begin
                        idx_d   = pick_rel_c[IDX_W-1:0];
                        grant_d = to_onehot(pick_rel_c[IDX_W-1:0]);
                        valid_d = 1'b1;
                        load_c  = 1'b1;
                    end else begin
                        grant_d = '0;
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, grant outputs and priority pointer registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign n_mult_en   = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;

endmodule

// File: tb/tb_arb_grant_sched.sv
// Self-checking bench for arb_grant_sched (SOURCES=4, MAX_BURST=4).
// Expected grants are queued when stimulus is driven and compared after the edge.
module tb_arb_grant_sched;

    localparam int S  = 4;
    localparam int MB = 4;
`ifdef ARB_SCHED_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic         clk;
    logic         n_rst;
    logic [S-1:0] req;
    logic         xfer_ready;
    logic         last;
    logic [S-1:0] n_mult_en;
    logic         grant_valid;
    logic [1:0]   grant_idx;

    int checks;
    int errors;

    logic [6:0] exp_q[$];

    // Reference model state.
    bit       m_busy;
    logic [1:0] m_ptr;
    logic [1:0] m_idx;
    int       m_cnt;

    arb_grant_sched #(
        .SOURCES   (S),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req         (req),
        .xfer_ready  (xfer_ready),
        .last        (last),
        .n_mult_en   (n_mult_en),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare it to the DUT outputs.
    task automatic compare_out(input string tag);
        logic [6:0] e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'({grant_valid, grant_idx, n_mult_en}), 32'(e));
        end
    endtask

    // Drive one cycle with a directed expectation for the grant after the edge.
    task automatic step(input string tag, input logic [3:0] r, input logic xr, input logic l,
                        input logic [3:0] eg, input logic [1:0] ei);
        req        = r;
        xfer_ready = xr;
        last       = l;
        exp_q.push_back({|eg, ei, eg});
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    function automatic logic [1:0] rr_search(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] c;
        c = p;
        for (int n = 0; n < 4; n++) begin
            if (r[c]) return c;
            c = c + 2'd1;
        end
        return 2'd0;
    endfunction

    // Advance the reference model by one clock with the given inputs.
    task automatic model_step(input logic [3:0] r, input logic xr, input logic l);
        bit         done;
        logic [3:0] masked;
        if (!m_busy) begin
            if (r != 4'd0) begin
                m_idx  = rr_search(r, m_ptr);
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else begin
            done = (r[m_idx] == 1'b0) || (xr && (!BURST || l || (m_cnt + 1 == MB)));
            if (done) begin
                m_ptr = m_idx + 2'd1;
                masked = r;
                masked[m_idx] = 1'b0;
                if (masked != 4'd0) begin
                    m_idx = rr_search(masked, m_ptr);
                    m_cnt = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (xr && m_cnt < MB) begin
                m_cnt++;
            end
        end
    endtask

    initial begin
        logic [3:0] r;
        logic       xr;
        logic       l;
        checks     = 0;
        errors     = 0;
        n_rst      = 1'b0;
        req        = 4'b1111;
        xfer_ready = 1'b0;
        last       = 1'b0;

        // Reset holds outputs clear even with all requests up.
        repeat (2) @(posedge clk);
        #1;
        check("rst_en",    32'(n_mult_en),   32'd0);
        check("rst_valid", 32'(grant_valid), 32'd0);
        check("rst_idx",   32'(grant_idx),   32'd0);
        n_rst = 1'b1;

`ifndef ARB_SCHED_BURST_EN
        step("first_grant",  4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0);
        step("rr1",          4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1);
        step("rr2",          4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2);
        step("rr3",          4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3);
        step("rr_wrap",      4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0);
        step("rr5",          4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1);
        step("withdraw",     4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1);
        step("idle_xr",      4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1);
        step("ptr_after_wd", 4'b0110, 1'b0, 1'b0, 4'b0100, 2'd2);
        step("to_ptr3",      4'b0101, 1'b1, 1'b0, 4'b0001, 2'd0);
        step("hold",         4'b0101, 1'b0, 1'b0, 4'b0001, 2'd0);
        step("skip",         4'b0101, 1'b1, 1'b0, 4'b0100, 2'd2);
        step("wrap_skip",    4'b0101, 1'b1, 1'b0, 4'b0001, 2'd0);
        step("simul_rel",    4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2);
        step("late_req",     4'b1111, 1'b0, 1'b0, 4'b0100, 2'd2);
        step("drain",        4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2);
`else
        step("b_first",      4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0);
        step("b_beat1",      4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0);
        step("b_beat2",      4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0);
        step("b_beat3",      4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0);
        step("b_beat4",      4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1);
        step("b_last1",      4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1);
        step("b_last2",      4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0);
        step("b_stall",      4'b0011, 1'b0, 1'b1, 4'b0001, 2'd0);
        step("b_withdraw",   4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0);
        step("b_idle_xr",    4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
        step("b_ptr",        4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1);
`endif

        // Asynchronous reset in the middle of a grant clears outputs at once.
        req        = 4'b1111;
        xfer_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(grant_valid), 32'd1);
        #3;
        n_rst = 1'b0;
        #1;
        check("async_en",    32'(n_mult_en),   32'd0);
        check("async_valid", 32'(grant_valid), 32'd0);
        check("async_idx",   32'(grant_idx),   32'd0);
        @(posedge clk);
        #1;
        n_rst  = 1'b1;
        m_busy = 1'b0;
        m_ptr  = 2'd0;
        m_idx  = 2'd0;
        m_cnt  = 0;

        // Random traffic against the reference model plus one-hot invariants.
        for (int i = 0; i < 10000; i++) begin
            r  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) r = 4'd0;
            xr = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 3) == 0);
            req        = r;
            xfer_ready = xr;
            last       = l;
            model_step(r, xr, l);
            exp_q.push_back({m_busy, m_idx, m_busy ? (4'd1 << m_idx) : 4'd0});
            @(posedge clk);
            #1;
            compare_out("rand");
            check("onehot",   32'($onehot0(n_mult_en)), 32'd1);
            check("valid_or", 32'(grant_valid),         32'(|n_mult_en));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
